// File: rtl/pointwise_intt_frontend_if.sv
// -----------------------------------------------------------------------------
// pointwise_intt_frontend_if
//   Stream interface of the pointwise-multiply / INTT frontend.
//   Input side : in_valid/in_ready handshake carrying one (in_a, in_b) pair.
//   Output side: out_valid/out_ready handshake carrying out_data + out_last.
//   master : the environment (pair producer, result sink)
//   slave  : the frontend
// -----------------------------------------------------------------------------
interface pointwise_intt_frontend_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/pointwise_intt_frontend.sv
// -----------------------------------------------------------------------------
// pointwise_intt_frontend
//   Feeder and drain around an inverse-NTT core. Takes N coefficient pairs,
//   multiplies each pair mod Q through a 2-stage pipeline and writes the
//   product to core address i, pulses the core start, waits for done, then
//   reads the N results back and streams them out.
// Ports
//   clk, rst_n           clock / asynchronous active-low reset
//   bus (slave)          in_valid/in_ready/in_a/in_b,
//                        out_valid/out_ready/out_data/out_last
//   busy_o               frame in progress (state != IDLE)
//   intt_start_o         one-cycle core start pulse
//   intt_done_i          core done, honoured only while waiting for it
//   intt_load_coeff_o    core write enable (stage-2 valid)
//   intt_load_addr_o     core write address
//   intt_load_data_o     core write data (a*b mod Q)
//   intt_read_addr_o     core read address (held through RD/CAP/OUT)
//   intt_read_data_i     core read data, one cycle after the address
// -----------------------------------------------------------------------------
module pointwise_intt_frontend #(
    parameter int              N              = 256,
    parameter int              WIDTH          = 32,
    parameter logic [WIDTH-1:0] Q             = 8380417,
    parameter int              ADDR_WIDTH     = 8,
    parameter int              REDUCTION_TYPE = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    pointwise_intt_frontend_if.slave  bus,
    output logic                      busy_o,
    output logic                      intt_start_o,
    input  logic                      intt_done_i,
    output logic                      intt_load_coeff_o,
    output logic [ADDR_WIDTH-1:0]     intt_load_addr_o,
    output logic [WIDTH-1:0]          intt_load_data_o,
    output logic [ADDR_WIDTH-1:0]     intt_read_addr_o,
    input  logic [WIDTH-1:0]          intt_read_data_i
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_RD    = 3'd5;
    localparam logic [2:0] S_CAP   = 3'd6;
    localparam logic [2:0] S_OUT   = 3'd7;

    localparam int                  STAGES   = 2;
    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(N-1);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH:0]   wr_idx_q, wr_idx_d;
    logic [ADDR_WIDTH:0]   rd_idx_q, rd_idx_d;
    logic                  in_ready_q, in_ready_d;
    logic [STAGES-1:0]     vld_pipe_q;     // [0] = S1 valid, [1] = S2 valid
    logic [WIDTH-1:0]      s1_a_q, s1_b_q;
    logic [ADDR_WIDTH-1:0] s1_idx_q, s2_idx_q;
    logic [WIDTH-1:0]      s2_data_q;
    logic [WIDTH-1:0]      out_data_q;
    logic                  in_fire;

    // in_ready is registered from the next state so it is 0 while in reset
    // and rises on the first edge after release.
    assign in_fire = bus.in_valid && in_ready_q;

    // -------------------------------------------------------------------------
    // Modular product: full 2*WIDTH-bit product, exact residue mod Q.
    // -------------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_full;
    logic [WIDTH-1:0]   prod_red;

    assign prod_full = {{WIDTH{1'b0}}, s1_a_q} * {{WIDTH{1'b0}}, s1_b_q};

    if (REDUCTION_TYPE == 0) begin : g_simple
        assign prod_red = WIDTH'(prod_full % {{WIDTH{1'b0}}, Q});
    end else begin : g_exact
        // Barrett/Montgomery selections must still hand the core the plain
        // residue (no Montgomery factor), so they share the direct reduction.
        assign prod_red = WIDTH'(prod_full % {{WIDTH{1'b0}}, Q});
    end

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (in_fire) begin
                    if (wr_idx_q == LAST_IDX) begin
                        state_d  = S_DRAIN;
                        wr_idx_d = '0;
                    end else begin
                        state_d  = S_LOAD;
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            S_DRAIN: if (vld_pipe_q == '0) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (intt_done_i) begin
                    state_d  = S_RD;
                    rd_idx_d = '0;
                end
            end
            S_RD:  state_d = S_CAP;
            S_CAP: state_d = S_OUT;
            S_OUT: begin
                if (bus.out_ready) begin
                    if (rd_idx_q == LAST_IDX) begin
                        state_d  = S_IDLE;
                        rd_idx_d = '0;
                    end else begin
                        state_d  = S_RD;
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            in_ready_q <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            in_ready_q <= in_ready_d;
            if (state_q == S_CAP) out_data_q <= intt_read_data_i;
        end
    end

    // -------------------------------------------------------------------------
    // Multiply pipeline: S1 captures the pair, S2 the reduced product.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_idx_q   <= '0;
            s2_idx_q   <= '0;
            s2_data_q  <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[STAGES-2:0], in_fire};
            if (in_fire) begin
                s1_a_q   <= bus.in_a;
                s1_b_q   <= bus.in_b;
                s1_idx_q <= wr_idx_q[ADDR_WIDTH-1:0];
            end
            if (vld_pipe_q[0]) begin
                s2_data_q <= prod_red;
                s2_idx_q  <= s1_idx_q;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = (state_q == S_OUT);
    assign bus.out_data      = out_data_q;
    assign bus.out_last      = (rd_idx_q == LAST_IDX);
    assign busy_o            = (state_q != S_IDLE);
    assign intt_start_o      = (state_q == S_START);
    assign intt_load_coeff_o = vld_pipe_q[STAGES-1];
    assign intt_load_addr_o  = s2_idx_q;
    assign intt_load_data_o  = s2_data_q;
    assign intt_read_addr_o  = rd_idx_q[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_pointwise_intt_frontend.sv
// -----------------------------------------------------------------------------
// tb_pointwise_intt_frontend
//   Directed sequence with randomized data and handshakes. A behavioural INTT
//   core (naive O(N^2) transform over a 256th root of unity mod Q) sits on the
//   core-side ports; expected results come from plain modular arithmetic.
// -----------------------------------------------------------------------------
module tb_pointwise_intt_frontend;
    localparam int     N     = 256;
    localparam int     WIDTH = 32;
    localparam int     AW    = 8;
    localparam longint Q     = 8380417;

    typedef longint vec_t [N];

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pointwise_intt_frontend_if #(.WIDTH(WIDTH)) bus ();

    logic             busy, intt_start, intt_done, intt_load_coeff;
    logic [AW-1:0]    intt_load_addr, intt_read_addr;
    logic [WIDTH-1:0] intt_load_data, intt_read_data;
    logic             core_done, spur_done;

    assign intt_done = core_done | spur_done;

    pointwise_intt_frontend #(
        .N(N), .WIDTH(WIDTH), .Q(32'd8380417), .ADDR_WIDTH(AW), .REDUCTION_TYPE(0)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus               (bus),
        .busy_o            (busy),
        .intt_start_o      (intt_start),
        .intt_done_i       (intt_done),
        .intt_load_coeff_o (intt_load_coeff),
        .intt_load_addr_o  (intt_load_addr),
        .intt_load_data_o  (intt_load_data),
        .intt_read_addr_o  (intt_read_addr),
        .intt_read_data_i  (intt_read_data)
    );

    int vectors = 0;
    int miscompares = 0;

    vec_t   wtab, witab;
    longint ninv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint modpow(input longint b, input longint e);
        longint r, bb, ee;
        r = 1; bb = b % Q; ee = e;
        while (ee > 0) begin
            if ((ee & 1) != 0) r = (r * bb) % Q;
            bb = (bb * bb) % Q;
            ee = ee >> 1;
        end
        return r;
    endfunction

    // Forward: y_k = sum x_j w^(jk); inverse: y_k = N^-1 sum x_j w^-(jk)
    task automatic xform(input vec_t x, input bit inv, output vec_t y);
        longint acc;
        for (int k = 0; k < N; k++) begin
            acc = 0;
            for (int j = 0; j < N; j++)
                acc = (acc + x[j] * (inv ? witab[(j*k)%N] : wtab[(j*k)%N])) % Q;
            y[k] = inv ? (acc * ninv) % Q : acc;
        end
    endtask

    // ---------------- behavioural INTT core ----------------
    vec_t core_mem, core_res;
    int   core_cnt = 0;

    initial begin : core_model
        core_done = 1'b0;
        intt_read_data = '0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                core_cnt = 0;
                core_done <= 1'b0;
            end else begin
                core_done <= 1'b0;
                if (intt_load_coeff) core_mem[intt_load_addr] = longint'(intt_load_data);
                if (intt_start) begin
                    xform(core_mem, 1'b1, core_res);
                    core_mem = core_res;
                    core_cnt = 6;
                end else if (core_cnt > 0) begin
                    core_cnt--;
                    if (core_cnt == 0) core_done <= 1'b1;
                end
                intt_read_data <= WIDTH'(core_mem[intt_read_addr]);
            end
        end
    end

    // ---------------- load / start logger ----------------
    logic [AW-1:0]    ld_addr_q [$];
    logic [WIDTH-1:0] ld_data_q [$];
    int               ld_cyc_q  [$];
    int cyc = 0, start_n = 0, start_cyc = 0, overlap_n = 0;

    initial begin : logger
        forever begin
            @(negedge clk);
            cyc++;
            if (intt_load_coeff) begin
                ld_addr_q.push_back(intt_load_addr);
                ld_data_q.push_back(intt_load_data);
                ld_cyc_q.push_back(cyc);
            end
            if (intt_start) begin
                start_n++;
                start_cyc = cyc;
            end
            if (intt_start && intt_load_coeff) overlap_n++;
        end
    end

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    vec_t av, bv, pv, ev, fa, fb;

    task automatic feed(input bit gaps, input int spur_at);
        int i, guard;
        i = 0; guard = 0;
        while (i < N && guard < 5000) begin
            @(negedge clk);
            guard++;
            spur_done    = (guard == spur_at);
            bus.in_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
            bus.in_a     = WIDTH'(av[i]);
            bus.in_b     = WIDTH'(bv[i]);
            if (bus.in_valid && bus.in_ready) i++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        spur_done    = 1'b0;
        chk("feed_pairs_accepted", i, N);
    endtask

    task automatic drain(input bit bp, input vec_t exp, input string tag);
        int j, guard, last_acc, bad_gap;
        logic stalled;
        logic [WIDTH-1:0] held;
        j = 0; guard = 0; last_acc = -1; bad_gap = 0; stalled = 1'b0; held = '0;
        while (j < N && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (stalled) begin
                chk({tag, "_stall_valid"}, bus.out_valid, 1);
                chk({tag, "_stall_data"}, bus.out_data, held);
            end
            bus.out_ready = bp ? 1'($urandom_range(1)) : 1'b1;
            stalled = bus.out_valid && !bus.out_ready;
            held    = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                chk({tag, "_data"}, bus.out_data, exp[j]);
                chk({tag, "_last"}, bus.out_last, (j == N-1));
                if (!bp && last_acc >= 0 && guard - last_acc != 3) bad_gap++;
                last_acc = guard;
                j++;
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_beats"}, j, N);
        chk({tag, "_idle_after"}, busy, 0);
        chk({tag, "_no_extra_valid"}, bus.out_valid, 0);
        if (!bp) chk({tag, "_3cycle_rate"}, bad_gap, 0);
    endtask

    task automatic check_loads(input int base, input vec_t p, input string tag);
        chk({tag, "_nloads"}, ld_addr_q.size() - base, N);
        for (int i = 0; i < N && base + i < ld_addr_q.size(); i++) begin
            chk({tag, "_ld_addr"}, ld_addr_q[base+i], i);
            chk({tag, "_ld_data"}, ld_data_q[base+i], p[i]);
        end
    endtask

    task automatic rand_vecs();
        for (int i = 0; i < N; i++) begin
            av[i] = $urandom_range(8380416);
            bv[i] = $urandom_range(8380416);
        end
    endtask

    task automatic make_expect();
        for (int i = 0; i < N; i++) pv[i] = (av[i] * bv[i]) % Q;
        xform(pv, 1'b1, ev);
    endtask

    // ---------------- directed sequence ----------------
    int base, s0, s1, d, guard, vcnt;
    longint w, winv;

    initial begin : main
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
        spur_done = 1'b0;
        w = modpow(1753, 2);             // 1753 is a primitive 512th root mod Q
        winv = modpow(w, Q-2);
        ninv = modpow(N, Q-2);
        for (int k = 0; k < N; k++) begin
            wtab[k]  = modpow(w, k);
            witab[k] = modpow(winv, k);
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_start", intt_start, 0);
        chk("rst_load_coeff", intt_load_coeff, 0);
        chk("rst_load_addr", intt_load_addr, 0);
        chk("rst_load_data", intt_load_data, 0);
        chk("rst_read_addr", intt_read_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_busy", busy, 0);

        // Load path: a_i = i, b_i = 1, back-to-back; stray done during LOAD
        for (int i = 0; i < N; i++) begin av[i] = i; bv[i] = 1; end
        make_expect();
        base = ld_addr_q.size(); s0 = start_n;
        feed(1'b0, 20);
        drain(1'b0, ev, "ramp");
        check_loads(base, pv, "ramp");
        chk("ramp_consecutive", ld_cyc_q[base+N-1] - ld_cyc_q[base], N-1);
        chk("ramp_one_start", start_n - s0, 1);
        d = start_cyc - ld_cyc_q[base+N-1];
        chk("ramp_start_after_last_load", (d >= 2 && d <= 3), 1);

        // Modular product corner cases
        rand_vecs();
        av[0] = 8380416; bv[0] = 8380416;
        av[1] = 4190209; bv[1] = 2;
        make_expect();
        base = ld_addr_q.size();
        feed(1'b1, -1);
        drain(1'b1, ev, "modq");
        check_loads(base, pv, "modq");
        chk("modq_minus1_sq", ld_data_q[base], 1);
        chk("modq_half_x2", ld_data_q[base+1], 1);

        // Round trip: A=[1,0..], B=[3,0..] forward transformed
        for (int i = 0; i < N; i++) begin fa[i] = (i == 0) ? 1 : 0; fb[i] = (i == 0) ? 3 : 0; end
        xform(fa, 1'b0, av);
        xform(fb, 1'b0, bv);
        for (int i = 0; i < N; i++) ev[i] = (i == 0) ? 3 : 0;
        base = ld_addr_q.size();
        feed(1'b0, -1);
        drain(1'b0, ev, "rtrip");
        chk("rtrip_pointwise", ld_data_q[base+7], 3);

        // Backpressure and input gaps
        for (int f = 0; f < 2; f++) begin
            rand_vecs();
            make_expect();
            base = ld_addr_q.size();
            feed(1'b1, -1);
            drain(1'b1, ev, "bp");
            check_loads(base, pv, "bp");
        end
        chk("no_start_with_load", overlap_n, 0);

        // Reset while waiting for the core
        rand_vecs();
        s0 = start_n;
        feed(1'b0, -1);
        guard = 0;
        while (start_n == s0 && guard < 200) begin @(negedge clk); guard++; end
        chk("wait_start_seen", start_n - s0, 1);
        repeat (2) @(negedge clk);
        chk("wait_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("wait_rst_busy", busy, 0);
        rst_n = 1'b1;
        s1 = start_n; vcnt = 0;
        repeat (20) begin @(negedge clk); if (bus.out_valid) vcnt++; end
        chk("wait_rst_no_out", vcnt, 0);
        chk("wait_rst_no_start", start_n - s1, 0);
        chk("wait_rst_in_ready", bus.in_ready, 1);

        // Reset while presenting a result
        rand_vecs();
        feed(1'b1, -1);
        guard = 0;
        while (!bus.out_valid && guard < 500) begin @(negedge clk); guard++; end
        chk("out_valid_seen", bus.out_valid, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("out_rst_valid", bus.out_valid, 0);
        chk("out_rst_busy", busy, 0);
        rst_n = 1'b1;
        s1 = start_n; vcnt = 0;
        repeat (10) begin @(negedge clk); if (bus.out_valid) vcnt++; end
        chk("out_rst_no_out", vcnt, 0);
        chk("out_rst_no_start", start_n - s1, 0);

        // Full frame after the aborts
        rand_vecs();
        make_expect();
        base = ld_addr_q.size();
        feed(1'b1, -1);
        drain(1'b1, ev, "recover");
        check_loads(base, pv, "recover");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
